// File: rtl/rx_qpsk_ber_checker_pkg.sv
// Shared definitions for the QPSK receive-side BER checker: FSM states, bit mapping, error helper.
package rx_qpsk_ber_checker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_SEARCH = 3'd2,
        ST_LOCKED = 3'd3,
        ST_FAIL   = 3'd4
    } state_t;

    // Bit carried by a negative amplitude; zero and positive amplitudes carry the complement.
    localparam logic NEG_BIT = 1'b1;

    function automatic logic slice(input logic sign);
        return sign ? NEG_BIT : ~NEG_BIT;
    endfunction

    function automatic logic [1:0] bit_errors(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] d;
        d = a ^ b;
        return {1'b0, d[1]} + {1'b0, d[0]};
    endfunction

endpackage

// File: rtl/rx_qpsk_ber_checker_ref_delay_line.sv
// Reference bit-pair delay line with a registered, run-time selectable tap.
module rx_qpsk_ber_checker_ref_delay_line #(
    parameter int MAX_DLY = 64,
    parameter int DLY_W   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       ref_bits,
    input  logic [DLY_W-1:0] sel,
    output logic [1:0]       tap
);

    localparam int HIST_W = 2 * (MAX_DLY - 1);

    // hist[2k+1:2k] holds the reference pair from k+1 symbols ago; tap 0 is the live input.
    logic [HIST_W-1:0] hist;
    logic [HIST_W+1:0] taps;

    assign taps = {hist, ref_bits};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= '0;
            tap  <= '0;
        end else if (in_valid) begin
            hist <= {hist[HIST_W-3:0], ref_bits};
            tap  <= taps[{sel, 1'b0} +: 2];
        end
    end

endmodule

// File: rtl/rx_qpsk_ber_checker.sv
// QPSK hard-decision slicer with automatic reference alignment and saturating BER counters.
module rx_qpsk_ber_checker
    import rx_qpsk_ber_checker_pkg::*;
#(
    parameter int DWIDTH  = 16,
    parameter int MAX_DLY = 64,
    parameter int DLY_W   = 6,
    parameter int WIN     = 128,
    parameter int ERR_THR = 8,
    parameter int LOL_THR = 32,
    parameter int CNT_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DWIDTH-1:0] rx_I,
    input  logic signed [DWIDTH-1:0] rx_Q,
    input  logic                     ref_bit_I,
    input  logic                     ref_bit_Q,
    input  logic                     start,
    output logic                     dec_valid,
    output logic                     dec_I,
    output logic                     dec_Q,
    output logic                     locked,
    output logic                     sync_fail,
    output logic [DLY_W-1:0]         align_delay,
    output logic [CNT_W-1:0]         err_count,
    output logic [CNT_W-1:0]         bit_count
);

    localparam int WE_W = $clog2(2 * WIN + 1);
    localparam int WC_W = $clog2(WIN);
    localparam int FC_W = $clog2(MAX_DLY);

    localparam logic [WE_W-1:0]  ERR_LIM   = WE_W'(ERR_THR);
    localparam logic [WE_W-1:0]  LOL_LIM   = WE_W'(LOL_THR);
    localparam logic [WC_W-1:0]  WIN_LAST  = WC_W'(WIN - 1);
    localparam logic [FC_W-1:0]  FILL_LAST = FC_W'(MAX_DLY - 1);
    localparam logic [DLY_W-1:0] CAND_LAST = DLY_W'(MAX_DLY - 1);

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] acc,
                                                  input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, acc} + (CNT_W + 1)'(inc);
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    state_t          state;
    logic [1:0]      tap_p1;
    logic [1:0]      sym_err;
    logic [WE_W-1:0] win_err;
    logic [WE_W-1:0] win_err_next;
    logic [WC_W-1:0] win_cnt;
    logic [FC_W-1:0] fill_cnt;
    logic            win_last;
    logic            unused_mag;

    // Hard decisions only need the sign; magnitude bits are intentionally dropped.
    assign unused_mag = ^{rx_I[DWIDTH-2:0], rx_Q[DWIDTH-2:0]};

    // Stage 1: slicer register, aligned with the registered reference tap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_valid <= 1'b0;
            dec_I     <= 1'b0;
            dec_Q     <= 1'b0;
        end else begin
            dec_valid <= in_valid;
            if (in_valid) begin
                dec_I <= slice(rx_I[DWIDTH-1]);
                dec_Q <= slice(rx_Q[DWIDTH-1]);
            end
        end
    end

    rx_qpsk_ber_checker_ref_delay_line #(
        .MAX_DLY (MAX_DLY),
        .DLY_W   (DLY_W)
    ) u_ref_dly (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .ref_bits ({ref_bit_I, ref_bit_Q}),
        .sel      (align_delay),
        .tap      (tap_p1)
    );

    assign sym_err      = bit_errors({dec_I, dec_Q}, tap_p1);
    assign win_err_next = win_err + WE_W'(sym_err);
    assign win_last     = (win_cnt == WIN_LAST);

    // Stage 2: comparison, window accounting, statistics and acquisition FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            locked      <= 1'b0;
            sync_fail   <= 1'b0;
            align_delay <= '0;
            fill_cnt    <= '0;
            win_cnt     <= '0;
            win_err     <= '0;
            err_count   <= '0;
            bit_count   <= '0;
        end else if (start) begin
            state       <= ST_FILL;
            locked      <= 1'b0;
            sync_fail   <= 1'b0;
            align_delay <= '0;
            fill_cnt    <= '0;
            win_cnt     <= '0;
            win_err     <= '0;
            err_count   <= '0;
            bit_count   <= '0;
        end else if (dec_valid) begin
            case (state)
                ST_FILL: begin
                    if (fill_cnt == FILL_LAST) begin
                        state    <= ST_SEARCH;
                        fill_cnt <= '0;
                        win_cnt  <= '0;
                        win_err  <= '0;
                    end else begin
                        fill_cnt <= fill_cnt + FC_W'(1);
                    end
                end
                ST_SEARCH: begin
                    if (win_last) begin
                        win_cnt <= '0;
                        win_err <= '0;
                        if (win_err_next <= ERR_LIM) begin
                            state  <= ST_LOCKED;
                            locked <= 1'b1;
                        end else if (align_delay == CAND_LAST) begin
                            state     <= ST_FAIL;
                            sync_fail <= 1'b1;
                        end else begin
                            align_delay <= align_delay + DLY_W'(1);
                        end
                    end else begin
                        win_cnt <= win_cnt + WC_W'(1);
                        win_err <= win_err_next;
                    end
                end
                ST_LOCKED: begin
                    err_count <= sat_add(err_count, sym_err);
                    bit_count <= sat_add(bit_count, 2'd2);
                    if (win_last) begin
                        win_cnt <= '0;
                        win_err <= '0;
                        // Statistics are frozen, not cleared, while re-acquiring.
                        if (win_err_next > LOL_LIM) begin
                            state       <= ST_SEARCH;
                            locked      <= 1'b0;
                            align_delay <= '0;
                        end
                    end else begin
                        win_cnt <= win_cnt + WC_W'(1);
                        win_err <= win_err_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_qpsk_ber_checker.sv
// Directed bench: slicer vector table plus acquisition, tracking, loss-of-lock, failure, reset and saturation sequences.
module tb_rx_qpsk_ber_checker;

    localparam int SEQ_N = 8400;

    typedef struct {
        logic signed [15:0] i;
        logic signed [15:0] q;
        logic               ei;
        logic               eq;
    } slv_t;

    logic clk = 1'b0;
    logic rst, in_valid, start, ref_bit_I, ref_bit_Q;
    logic signed [15:0] rx_I, rx_Q;

    logic        dec_valid, dec_I, dec_Q, locked, sync_fail;
    logic [5:0]  align_delay;
    logic [31:0] err_count, bit_count;

    logic        dec_valid8, dec_I8, dec_Q8, locked8, sync_fail8;
    logic [5:0]  align_delay8;
    logic [7:0]  err8, bit8;

    int          total = 0;
    int          bad = 0;
    int          n = 0;
    int          lol_sym;
    logic [1:0]  seq9  [SEQ_N];
    logic [1:0]  seq15 [SEQ_N];
    logic [8:0]  lfsr9;
    logic [14:0] lfsr15;
    logic [31:0] held_err;
    slv_t        vec [5];

    always #5 clk = ~clk;

    rx_qpsk_ber_checker dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .rx_I(rx_I), .rx_Q(rx_Q),
        .ref_bit_I(ref_bit_I), .ref_bit_Q(ref_bit_Q), .start(start),
        .dec_valid(dec_valid), .dec_I(dec_I), .dec_Q(dec_Q), .locked(locked),
        .sync_fail(sync_fail), .align_delay(align_delay),
        .err_count(err_count), .bit_count(bit_count)
    );

    rx_qpsk_ber_checker #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .rx_I(rx_I), .rx_Q(rx_Q),
        .ref_bit_I(ref_bit_I), .ref_bit_Q(ref_bit_Q), .start(start),
        .dec_valid(dec_valid8), .dec_I(dec_I8), .dec_Q(dec_Q8), .locked(locked8),
        .sync_fail(sync_fail8), .align_delay(align_delay8),
        .err_count(err8), .bit_count(bit8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] rxb, input logic [1:0] refb);
        @(posedge clk); #1;
        in_valid  = 1'b1;
        rx_I      = rxb[1] ? -16'sd8192 : 16'sd8192;
        rx_Q      = rxb[0] ? -16'sd8192 : 16'sd8192;
        ref_bit_I = refb[1];
        ref_bit_Q = refb[0];
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // mode 0 clean, 1 flips I on every 16th symbol, 2 flips both bits; ref15 uses the unrelated PRBS15 reference.
    task automatic run(input int cnt, input int dly, input int mode, input bit ref15, input bit gaps);
        logic [1:0] rxb, refb;
        for (int i = 0; i < cnt; i++) begin
            rxb = seq9[n];
            if (mode == 1 && (i % 16) == 15) rxb[1] = ~rxb[1];
            if (mode == 2) rxb = ~rxb;
            refb = ref15 ? seq15[n] : seq9[n + dly];
            send(rxb, refb);
            n++;
            if (gaps) begin
                idle();
                idle();
            end
        end
    endtask

    task automatic do_start();
        @(posedge clk); #1;
        in_valid = 1'b0;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n     = 0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; start = 1'b0;
        rx_I = '0; rx_Q = '0; ref_bit_I = 1'b0; ref_bit_Q = 1'b0;

        lfsr9  = 9'h1FF;
        lfsr15 = 15'h7FFF;
        for (int k = 0; k < SEQ_N; k++) begin
            for (int b = 0; b < 2; b++) begin
                lfsr9  = {lfsr9[7:0], lfsr9[8] ^ lfsr9[4]};
                lfsr15 = {lfsr15[13:0], lfsr15[14] ^ lfsr15[13]};
                seq9[k]  = {seq9[k][0], lfsr9[0]};
                seq15[k] = {seq15[k][0], lfsr15[0]};
            end
        end

        vec[0] = '{16'sd0,      -16'sd1,     1'b0, 1'b1};
        vec[1] = '{16'sd32767,  -16'sd32768, 1'b0, 1'b1};
        vec[2] = '{-16'sd1,     16'sd1,      1'b1, 1'b0};
        vec[3] = '{-16'sd8192,  16'sd8192,   1'b1, 1'b0};
        vec[4] = '{-16'sd32768, 16'sd0,      1'b1, 1'b0};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dec_valid", 64'(dec_valid), 64'd0);
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_sync_fail", 64'(sync_fail), 64'd0);
        chk("rst_align", 64'(align_delay), 64'd0);
        chk("rst_err", 64'(err_count), 64'd0);
        chk("rst_bits", 64'(bit_count), 64'd0);
        rst = 1'b0;

        // slicer table
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            rx_I = vec[k].i;
            rx_Q = vec[k].q;
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk($sformatf("slice%0d_valid", k), 64'(dec_valid), 64'd1);
            chk($sformatf("slice%0d_I", k), 64'(dec_I), 64'(vec[k].ei));
            chk($sformatf("slice%0d_Q", k), 64'(dec_Q), 64'(vec[k].eq));
        end
        @(posedge clk); #1;
        chk("slice_valid_drop", 64'(dec_valid), 64'd0);
        chk("idle_no_lock", 64'(locked), 64'd0);

        // case 1: clean channel, reference 5 symbols ahead
        do_start();
        run(64 + 6 * 128, 5, 0, 1'b0, 1'b0);
        idle();
        chk("c1_lock_latency", 64'(locked), 64'd0);
        idle();
        chk("c1_locked", 64'(locked), 64'd1);
        chk("c1_align", 64'(align_delay), 64'd5);
        chk("c1_err", 64'(err_count), 64'd0);
        chk("c1_bits", 64'(bit_count), 64'd0);
        chk("c1_locked8", 64'(locked8), 64'd1);

        // case 2: one I-bit error every 16 symbols
        run(1600, 5, 1, 1'b0, 1'b0);
        idle(); idle();
        chk("c2_err", 64'(err_count), 64'd100);
        chk("c2_bits", 64'(bit_count), 64'd3200);
        chk("c2_locked", 64'(locked), 64'd1);
        chk("c2_bits8_sat", 64'(bit8), 64'd255);
        chk("c2_err8", 64'(err8), 64'd100);

        // case 4: reference delay jumps to 9
        lol_sym = -1;
        for (int k = 0; k < 400; k++) begin
            run(1, 9, 0, 1'b0, 1'b0);
            idle(); idle();
            if (!locked) begin
                lol_sym = k + 1;
                break;
            end
        end
        if (lol_sym < 0) begin
            chk("c4_lol_timeout", 64'(locked), 64'd0);
        end else begin
            chk("c4_lol_window_end", 64'(lol_sym % 128), 64'd64);
            chk("c4_lol_bits", 64'(bit_count), 64'(3200 + 2 * lol_sym));
        end
        held_err = err_count;
        chk("c4_search_align", 64'(align_delay), 64'd0);
        run(10 * 128, 9, 0, 1'b0, 1'b0);
        idle(); idle();
        chk("c4_relocked", 64'(locked), 64'd1);
        chk("c4_align", 64'(align_delay), 64'd9);
        chk("c4_err_held", 64'(err_count), 64'(held_err));
        chk("c4_bits_held", 64'(bit_count), 64'(3200 + 2 * lol_sym));

        // case 3: unrelated reference, every delay rejected
        do_start();
        chk("c3_start_clears", 64'(bit_count), 64'd0);
        run(64 + 64 * 128, 0, 0, 1'b1, 1'b0);
        idle();
        chk("c3_fail_latency", 64'(sync_fail), 64'd0);
        idle();
        chk("c3_sync_fail", 64'(sync_fail), 64'd1);
        chk("c3_locked", 64'(locked), 64'd0);
        chk("c3_align", 64'(align_delay), 64'd63);
        do_start();
        chk("c3_restart_fail", 64'(sync_fail), 64'd0);
        chk("c3_restart_align", 64'(align_delay), 64'd0);

        // case 6: case 1 with one valid symbol every three cycles
        run(64 + 6 * 128, 5, 0, 1'b0, 1'b1);
        chk("c6_locked", 64'(locked), 64'd1);
        chk("c6_align", 64'(align_delay), 64'd5);
        chk("c6_err", 64'(err_count), 64'd0);
        chk("c6_bits", 64'(bit_count), 64'd0);
        run(40, 5, 0, 1'b0, 1'b0);
        idle(); idle();
        chk("c6_bits40", 64'(bit_count), 64'd80);

        // asynchronous reset mid-lock
        run(10, 5, 0, 1'b0, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk("c6_rst_valid", 64'(dec_valid), 64'd0);
        chk("c6_rst_locked", 64'(locked), 64'd0);
        chk("c6_rst_align", 64'(align_delay), 64'd0);
        chk("c6_rst_bits", 64'(bit_count), 64'd0);
        chk("c6_rst_bits8", 64'(bit8), 64'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        run(200, 5, 0, 1'b0, 1'b0);
        idle(); idle();
        chk("c6_idle_after_rst", 64'(locked), 64'd0);

        // case 5: 8-bit counter saturation
        do_start();
        run(64 + 6 * 128, 5, 0, 1'b0, 1'b0);
        idle(); idle();
        chk("c5_locked8", 64'(locked8), 64'd1);
        run(127, 5, 0, 1'b0, 1'b0);
        idle(); idle();
        chk("c5_bits8_254", 64'(bit8), 64'd254);
        run(1, 5, 0, 1'b0, 1'b0);
        idle(); idle();
        chk("c5_bits8_255", 64'(bit8), 64'd255);
        chk("c5_still_locked8", 64'(locked8), 64'd1);
        run(127, 5, 2, 1'b0, 1'b0);
        idle(); idle();
        chk("c5_err8_254", 64'(err8), 64'd254);
        chk("c5_locked8_mid", 64'(locked8), 64'd1);
        run(1, 5, 2, 1'b0, 1'b0);
        idle(); idle();
        chk("c5_err8_255", 64'(err8), 64'd255);
        chk("c5_bits8_hold", 64'(bit8), 64'd255);
        chk("c5_lol8", 64'(locked8), 64'd0);
        chk("c5_err32", 64'(err_count), 64'd256);
        chk("c5_bits32", 64'(bit_count), 64'd512);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
